// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop bits out on tx.
// Parity is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        baud_cnt;
  logic [BIT_W-1:0]        bit_count;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    tx_next;
  logic                    accept;
  logic                    bit_done;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q;
`endif

  assign accept   = tx_valid && (state == IDLE);
  assign bit_done = (state != IDLE) && (baud_cnt == BAUD_LAST);

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && bit_count == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP:  if (bit_done && bit_count == STOP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the upcoming state so the line changes on the same edge as the FSM.
  always_comb begin
    shift_next = shift_reg;
    if (accept)                        shift_next = tx_data;
    else if (state == DATA && bit_done) shift_next = shift_reg >> 1;

    tx_ready = (state == IDLE);
    tx_busy  = !tx_ready;

    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_q;
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      shift_reg <= shift_next;
      tx        <= tx_next;

      if (accept || state == IDLE || bit_done) baud_cnt <= '0;
      else                                     baud_cnt <= baud_cnt + 1'b1;

      // bit_count indexes data bits, then is reused to count stop bits.
      if (accept)        bit_count <= '0;
      else if (bit_done) bit_count <= (state_next == state) ? bit_count + 1'b1 : '0;

`ifdef UART_TX_PARITY_EN
      if (accept) parity_q <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule
